// File: rtl/avalon_reader_pkg.sv
// Shared types and default widths for the Avalon-MM block reader.
package avalon_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/avalon_block_reader_if.sv
// Avalon-MM read-master signals plus the streaming output port of the block reader.
interface avalon_block_reader_if
  import avalon_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_byteenable,
    input  avm_waitrequest, avm_readdata,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_byteenable,
    output avm_waitrequest, avm_readdata,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/avalon_reader_fifo.sv
// Synchronous FIFO for the block reader; output word is read straight from the storage registers.
module avalon_reader_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop_s;

  assign do_pop_s = pop_i && (count_q != CNT_ZERO);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_i, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != CNT_ZERO);

endmodule

// File: rtl/avalon_block_reader.sv
// Reads a block of words over Avalon-MM and streams them out in address order.
// Define AVALON_BLOCK_READER_CHECKSUM_EN to add the running output checksum port.
module avalon_block_reader
  import avalon_reader_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  avalon_block_reader_if.master bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = LEN_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        remaining_q, remaining_d;
  // Words reserved against FIFO space: reads in flight plus words held in the FIFO.
  logic [CNT_W-1:0]        reserved_q, reserved_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic                    read_q, read_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept_s, pop_s, fifo_valid_s;
  logic [DATA_W-1:0]       fifo_data_s;

  assign accept_s = read_q & ~bus.avm_waitrequest;
  assign pop_s    = fifo_valid_s & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    reserved_d  = reserved_q;
    done_d      = 1'b0;
    vld_d       = vld_q << 1;
    vld_d[0]    = accept_s;
    case ({accept_s, pop_s})
      2'b10:   reserved_d = reserved_q + CNT_ONE;
      2'b01:   reserved_d = reserved_q - CNT_ONE;
      default: reserved_d = reserved_q;
    endcase
    if (accept_s) begin
      addr_d      = addr_q + ADDR_ONE;
      remaining_d = remaining_q - LEN_ONE;
    end else begin
      addr_d      = addr_q;
      remaining_d = remaining_q;
    end
    case (state_q)
      IDLE: begin
        if (start && (length != LEN_ZERO)) begin
          state_d     = ISSUE;
          addr_d      = base_addr;
          remaining_d = length;
        end else if (start) begin
          done_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (accept_s && (remaining_q == LEN_ONE)) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (reserved_d == CNT_ZERO) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
    // A stalled read keeps reserved constant or shrinking, so avm_read cannot drop under waitrequest.
    read_d = (state_d == ISSUE) && (reserved_d < CNT_DEPTH);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= {ADDR_W{1'b0}};
      remaining_q <= {LEN_W{1'b0}};
      reserved_q  <= {CNT_W{1'b0}};
      vld_q       <= {READ_LATENCY{1'b0}};
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      reserved_q  <= reserved_d;
      vld_q       <= vld_d;
      read_q      <= read_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  avalon_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (vld_q[READ_LATENCY-1]),
    .data_i  (bus.avm_readdata),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .valid_o (fifo_valid_s)
  );

`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == IDLE) && start) begin
      sum_d = {DATA_W{1'b0}};
    end else if (pop_s) begin
      sum_d = sum_q + fifo_data_s;
    end else begin
      sum_d = sum_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= {DATA_W{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

  assign busy               = busy_q;
  assign done               = done_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_chipselect = read_q;
  assign bus.avm_byteenable = {(DATA_W/8){1'b1}};
  assign bus.out_data       = fifo_data_s;
  assign bus.out_valid      = fifo_valid_s;

endmodule

// File: tb/tb_avalon_block_reader.sv
// Directed and randomized bench for avalon_block_reader against a fixed-latency memory model.
module tb_avalon_block_reader;
  import avalon_reader_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned RL    = 1;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  avalon_block_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  avalon_block_reader #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave memory: fixed latency, garbage on readdata when nothing was accepted.
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] pipe_q [RL];
  always @(posedge clk) begin
    pipe_q[0] <= (bus.avm_read && !bus.avm_waitrequest) ? mem[bus.avm_address] : $urandom;
    for (int k = 1; k < int'(RL); k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign bus.avm_readdata = pipe_q[RL-1];

  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  logic [AW-1:0] got_addr[$];
  int            done_cnt = 0, done_cyc = 0, hold_err = 0, cs_err = 0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // Observe the bus mid-cycle, when everything for the coming edge is settled.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(bus.avm_read === 1'b1 && bus.avm_address === prev_addr)) hold_err++;
      if (bus.avm_chipselect !== bus.avm_read) cs_err++;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got_data.push_back(bus.out_data);
        got_cyc.push_back(cyc);
      end
      if (bus.avm_read === 1'b1 && bus.avm_waitrequest === 1'b0) got_addr.push_back(bus.avm_address);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = (bus.avm_read === 1'b1) && (bus.avm_waitrequest === 1'b1);
      prev_addr  = bus.avm_address;
    end
  end

  int ready_mode = 1;  // 0 low, 1 high, 2 random
  int wait_mode  = 0;  // 0 none, 1 random, 2 stall second read
  int stall_left = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (wait_mode == 1) begin
      bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
    end else if (wait_mode == 2 && bus.avm_read === 1'b1 && got_addr.size() == 1 && stall_left > 0) begin
      bus.avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      bus.avm_waitrequest = 1'b0;
    end
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int len);
    got_data.delete();
    got_cyc.delete();
    got_addr.delete();
    done_cnt  = 0;
    start     = 1'b1;
    base_addr = b;
    length    = (AW+1)'(len);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "/done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) tick();
  endtask

  // Reference: the block is simply mem[base], mem[base+1], ... with 10-bit address wrap.
  task automatic check_block(input string tag, input logic [AW-1:0] b, input int len);
    logic [DW-1:0] exp_w;
    logic [DW-1:0] sum = '0;
    logic [AW-1:0] exp_a;
    check({tag, "/words"}, 64'(got_data.size()), 64'(len));
    check({tag, "/reads"}, 64'(got_addr.size()), 64'(len));
    for (int i = 0; i < len; i++) begin
      exp_a = AW'((int'(b) + i) % 1024);
      exp_w = mem[exp_a];
      sum   = sum + exp_w;
      check($sformatf("%s/word%0d", tag, i), 64'((i < got_data.size()) ? got_data[i] : ~exp_w), 64'(exp_w));
      check($sformatf("%s/addr%0d", tag, i), 64'((i < got_addr.size()) ? got_addr[i] : ~exp_a), 64'(exp_a));
    end
    check({tag, "/done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "/busy_after"}, 64'(busy), 64'd0);
    check({tag, "/hold"}, 64'(hold_err), 64'd0);
    check({tag, "/chipselect"}, 64'(cs_err), 64'd0);
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
    check({tag, "/checksum"}, 64'(checksum), 64'(sum));
`endif
  endtask

  initial begin
    logic [AW-1:0] b;
    int            len;
    int            n;
    bus.out_ready       = 1'b1;
    bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/read", 64'(bus.avm_read), 64'd0);
    check("rst/cs", 64'(bus.avm_chipselect), 64'd0);
    check("rst/addr", 64'(bus.avm_address), 64'd0);
    check("rst/out_valid", 64'(bus.out_valid), 64'd0);
    check("rst/out_data", 64'(bus.out_data), 64'd0);
    check("rst/byteenable", 64'(bus.avm_byteenable), 64'hF);
    reset_n = 1'b1;
    tick();

    // Basic block with identity memory, full rate.
    do_start(10'h010, 4);
    wait_done("basic", 60);
    check_block("basic", 10'h010, 4);
    for (int i = 1; i < 4; i++)
      check($sformatf("basic/back_to_back%0d", i),
            64'((i < got_cyc.size()) ? got_cyc[i] - got_cyc[0] : -1), 64'(i));
    check("basic/done_after_last", 64'(got_cyc.size() == 4 && done_cyc >= got_cyc[3] + 1 && done_cyc <= got_cyc[3] + 2), 64'd1);
`ifdef AVALON_BLOCK_READER_CHECKSUM_EN
    check("basic/checksum_const", 64'(checksum), 64'h46);
`endif

    do_start(10'h3FE, 4);
    wait_done("wrap", 60);
    check_block("wrap", 10'h3FE, 4);

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    // Downstream stalled for 10 cycles.
    ready_mode = 0;
    b = AW'($urandom);
    do_start(b, 8);
    repeat (10) tick();
    check("stall/reads_bounded", 64'(got_addr.size() <= int'(DEPTH)), 64'd1);
    check("stall/no_transfer", 64'(got_data.size()), 64'd0);
    check("stall/out_valid", 64'(bus.out_valid), 64'd1);
    ready_mode = 1;
    wait_done("stall", 100);
    check_block("stall", b, 8);

    // Three-cycle waitrequest on the second read.
    wait_mode  = 2;
    stall_left = 3;
    b = AW'($urandom);
    do_start(b, 6);
    wait_done("waitreq", 100);
    check_block("waitreq", b, 6);
    check("waitreq/stalls_used", 64'(stall_left), 64'd0);
    wait_mode = 0;

    // Zero-length request.
    do_start(AW'($urandom), 0);
    tick();
    check("len0/done_next", 64'(done), 64'd1);
    check("len0/busy", 64'(busy), 64'd0);
    repeat (3) tick();
    check("len0/no_read", 64'(got_addr.size()), 64'd0);
    check("len0/done_pulses", 64'(done_cnt), 64'd1);

    // Start while busy must be ignored.
    b = AW'($urandom);
    do_start(b, 6);
    tick();
    tick();
    check("busy/busy_high", 64'(busy), 64'd1);
    start     = 1'b1;
    base_addr = b + AW'(100);
    length    = 11'd3;
    wait_done("busy", 100);
    check_block("busy", b, 6);

    // Randomized blocks with random stalls on both sides.
    ready_mode = 2;
    wait_mode  = 1;
    for (int r = 0; r < 4; r++) begin
      b   = AW'($urandom);
      len = $urandom_range(1, 40);
      do_start(b, len);
      wait_done($sformatf("rand%0d", r), 2000);
      check_block($sformatf("rand%0d", r), b, len);
    end
    ready_mode = 1;
    wait_mode  = 0;
    tick();

    // Reset in the middle of a block, released while a read is still in flight.
    b = AW'($urandom);
    do_start(b, 8);
    n = 0;
    while (got_data.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    check("midrst/three_words", 64'(got_data.size() >= 3), 64'd1);
    reset_n = 1'b0;
    #1;
    check("midrst/busy", 64'(busy), 64'd0);
    check("midrst/done", 64'(done), 64'd0);
    check("midrst/read", 64'(bus.avm_read), 64'd0);
    check("midrst/cs", 64'(bus.avm_chipselect), 64'd0);
    check("midrst/addr", 64'(bus.avm_address), 64'd0);
    check("midrst/out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst/out_data", 64'(bus.out_data), 64'd0);
    #2 reset_n = 1'b1;
    got_data.delete();
    got_addr.delete();
    done_cnt = 0;
    repeat (4) tick();
    check("midrst/stale_ignored", 64'(got_data.size()), 64'd0);
    check("midrst/idle_valid", 64'(bus.out_valid), 64'd0);
    check("midrst/idle_busy", 64'(busy), 64'd0);
    b = AW'($urandom);
    do_start(b, 5);
    wait_done("after_rst", 100);
    check_block("after_rst", b, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
